// File: rtl/field_edit_ctrl.sv
// field_edit_ctrl: IDLE/EDIT/COMMIT controller that walks the six RTC fields, steps them with UP/DOWN
// pulses and requests an RTC write on commit. Define FIELD_EDIT_AUTOREPEAT_EN for held-button auto-repeat.
module field_edit_ctrl #(
   parameter int TIMEOUT    = 100000000,
   parameter int REPEAT_DLY = 50000000,
   parameter int REPEAT_PER = 10000000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       BTN_EDIT,
   input  logic       BTN_UP,
   input  logic       BTN_DOWN,
   input  logic       RTC_RD_VALID,
   input  logic       WR_ACK,
   output logic [5:0] MOD,
   output logic       UP_P,
   output logic       DOWN_P,
   output logic       ACT,
   output logic       WR_REQ,
   output logic [2:0] FIELD,
   output logic       BUSY
);

   localparam int            TW       = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EDIT = 2'd1, ST_COMMIT = 2'd2} state_t;

   state_t        r_state, w_state_nxt;
   logic [2:0]    r_field, w_field_nxt;
   logic [5:0]    r_mod, w_mod_nxt;
   logic          r_up, w_up_nxt;
   logic          r_dn, w_dn_nxt;
   logic          r_act, w_act_nxt;
   logic          r_wr, w_wr_nxt;
   logic          r_busy, w_busy_nxt;
   logic [TW-1:0] r_tmo, w_tmo_nxt;
   logic [2:0]    r_btn_s1, r_btn_s2;
   logic [2:0]    w_rise;
   logic          w_up_ev, w_dn_ev, w_hold, w_rep_up, w_rep_dn;

   // bit0 EDIT, bit1 UP, bit2 DOWN; s1 holds this edge's sample, s2 the previous edge's
   assign w_rise  = r_btn_s1 & ~r_btn_s2;
   assign w_up_ev = w_rise[1] & ~r_btn_s1[2];
   assign w_dn_ev = w_rise[2] & ~r_btn_s1[1];

`ifdef FIELD_EDIT_AUTOREPEAT_EN
   localparam int            RMAX         = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int            RW           = $clog2(RMAX + 1);
   localparam logic [RW-1:0] REP_DLY_LAST = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] REP_PER_LAST = RW'(REPEAT_PER - 1);

   logic [RW-1:0] r_rep;
   logic          r_rep_first;
   logic          w_up_hold, w_dn_hold, w_rep_fire;

   assign w_up_hold  = r_btn_s1[1] & r_btn_s2[1] & ~r_btn_s1[2];
   assign w_dn_hold  = r_btn_s1[2] & r_btn_s2[2] & ~r_btn_s1[1];
   assign w_hold     = (r_state == ST_EDIT) & (w_up_hold | w_dn_hold);
   assign w_rep_fire = w_hold & (r_rep == (r_rep_first ? REP_DLY_LAST : REP_PER_LAST));
   assign w_rep_up   = w_rep_fire & w_up_hold;
   assign w_rep_dn   = w_rep_fire & w_dn_hold;

   // Cycles since the last pulse of the current hold: first gap REPEAT_DLY, then REPEAT_PER
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_rep       <= '0;
         r_rep_first <= 1'b1;
      end else if (!w_hold) begin
         r_rep       <= '0;
         r_rep_first <= 1'b1;
      end else if (w_rep_fire) begin
         r_rep       <= '0;
         r_rep_first <= 1'b0;
      end else begin
         r_rep       <= r_rep + RW'(1);
      end
   end
`else
   assign w_hold   = 1'b0;
   assign w_rep_up = 1'b0;
   assign w_rep_dn = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_field_nxt = r_field;
      w_tmo_nxt   = '0;
      w_up_nxt    = 1'b0;
      w_dn_nxt    = 1'b0;
      w_act_nxt   = 1'b0;
      w_wr_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise[0]) begin
               w_state_nxt = ST_EDIT;
               w_field_nxt = 3'd0;
            end else begin
               w_act_nxt = RTC_RD_VALID;
            end
         end
         ST_EDIT: begin
            if (w_rise[0]) begin
               if (r_field == 3'd5) begin
                  w_state_nxt = ST_COMMIT;
                  w_field_nxt = 3'd0;
                  w_wr_nxt    = 1'b1;
               end else begin
                  w_field_nxt = r_field + 3'd1;
               end
            end else begin
               w_up_nxt = w_up_ev | w_rep_up;
               w_dn_nxt = w_dn_ev | w_rep_dn;
               // Any button activity restarts the idle window; otherwise count towards abort
               if (!((|w_rise) | w_hold)) begin
                  w_tmo_nxt = (r_tmo == TMO_MAX) ? r_tmo : r_tmo + TW'(1);
                  if (r_tmo >= TMO_LAST) begin
                     w_state_nxt = ST_IDLE;
                     w_field_nxt = 3'd0;
                     w_tmo_nxt   = '0;
                  end
               end
            end
         end
         ST_COMMIT: begin
            if (WR_ACK) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_wr_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_field_nxt = 3'd0;
         end
      endcase
      w_mod_nxt  = (w_state_nxt == ST_EDIT) ? (6'd1 << w_field_nxt) : 6'd0;
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state  <= ST_IDLE;
         r_field  <= 3'd0;
         r_mod    <= 6'd0;
         r_up     <= 1'b0;
         r_dn     <= 1'b0;
         r_act    <= 1'b0;
         r_wr     <= 1'b0;
         r_busy   <= 1'b0;
         r_tmo    <= '0;
         r_btn_s1 <= 3'd0;
         r_btn_s2 <= 3'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_field  <= w_field_nxt;
         r_mod    <= w_mod_nxt;
         r_up     <= w_up_nxt;
         r_dn     <= w_dn_nxt;
         r_act    <= w_act_nxt;
         r_wr     <= w_wr_nxt;
         r_busy   <= w_busy_nxt;
         r_tmo    <= w_tmo_nxt;
         r_btn_s1 <= {BTN_DOWN, BTN_UP, BTN_EDIT};
         r_btn_s2 <= r_btn_s1;
      end
   end

   assign MOD    = r_mod;
   assign UP_P   = r_up;
   assign DOWN_P = r_dn;
   assign ACT    = r_act;
   assign WR_REQ = r_wr;
   assign FIELD  = r_field;
   assign BUSY   = r_busy;

endmodule

// File: tb/tb_field_edit_ctrl.sv
// Bench for field_edit_ctrl: directed scenarios plus random single-button traffic against a behavioural model.
// Honours FIELD_EDIT_AUTOREPEAT_EN so the same bench covers both builds.
module tb_field_edit_ctrl;

   localparam int TO = 20;
   localparam int RD = 8;
   localparam int RP = 3;
`ifdef FIELD_EDIT_AUTOREPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif
   localparam int M_IDLE = 0;
   localparam int M_EDIT = 1;
   localparam int M_COMMIT = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       b_edit = 1'b0, b_up = 1'b0, b_dn = 1'b0, rtc = 1'b0, ack = 1'b0;
   logic [5:0] mod;
   logic [2:0] field;
   logic       up_p, dn_p, act, wr_req, busy;

   int total = 0;
   int bad = 0;

   // Reference model state
   int         m_mode, m_field, m_quiet, m_hu, m_hd;
   logic [2:0] m_p1, m_p2;
   logic [5:0] e_mod;
   logic [2:0] e_field;
   logic       e_up, e_dn, e_act, e_wr, e_busy;

   field_edit_ctrl #(.TIMEOUT(TO), .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut (
      .CLK(clk), .RST(rst), .BTN_EDIT(b_edit), .BTN_UP(b_up), .BTN_DOWN(b_dn),
      .RTC_RD_VALID(rtc), .WR_ACK(ack), .MOD(mod), .UP_P(up_p), .DOWN_P(dn_p),
      .ACT(act), .WR_REQ(wr_req), .FIELD(field), .BUSY(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic model_reset();
      m_mode = M_IDLE; m_field = 0; m_quiet = 0; m_hu = 0; m_hd = 0;
      m_p1 = 3'd0; m_p2 = 3'd0;
      e_mod = 6'd0; e_field = 3'd0; e_up = 0; e_dn = 0; e_act = 0; e_wr = 0; e_busy = 0;
   endtask

   // Expected outputs after the coming clock edge, given the inputs sampled at it
   task automatic model_step(input logic [2:0] b, input logic r, input logic a);
      logic er, ur, dr, pu, pd, activity;
      er = m_p1[0] & ~m_p2[0];
      ur = m_p1[1] & ~m_p2[1];
      dr = m_p1[2] & ~m_p2[2];
      m_hu = (m_p1[1] && !m_p1[2]) ? m_hu + 1 : 0;
      m_hd = (m_p1[2] && !m_p1[1]) ? m_hd + 1 : 0;
      pu = (ur && m_hu == 1) || (AUTO && m_hu > RD && ((m_hu - 1 - RD) % RP) == 0);
      pd = (dr && m_hd == 1) || (AUTO && m_hd > RD && ((m_hd - 1 - RD) % RP) == 0);
      activity = er | ur | dr | (AUTO && (m_hu > 1 || m_hd > 1));
      e_up = 0; e_dn = 0; e_act = 0;
      case (m_mode)
         M_IDLE: begin
            if (er) begin m_mode = M_EDIT; m_field = 0; m_quiet = 0; end
            else e_act = r;
         end
         M_EDIT: begin
            if (er) begin
               if (m_field == 5) m_mode = M_COMMIT;
               else m_field = m_field + 1;
               m_quiet = 0;
            end else begin
               e_up = pu; e_dn = pd;
               if (activity) m_quiet = 0;
               else begin
                  m_quiet = m_quiet + 1;
                  if (m_quiet == TO) m_mode = M_IDLE;
               end
            end
         end
         default: if (a) m_mode = M_IDLE;
      endcase
      m_p2 = m_p1; m_p1 = b;
      e_field = (m_mode == M_EDIT) ? 3'(m_field) : 3'd0;
      e_mod   = (m_mode == M_EDIT) ? (6'd1 << m_field) : 6'd0;
      e_wr    = (m_mode == M_COMMIT);
      e_busy  = (m_mode != M_IDLE);
   endtask

   task automatic drive(input logic e, input logic u, input logic d, input logic r, input logic a);
      b_edit = e; b_up = u; b_dn = d; rtc = r; ack = a;
      model_step({d, u, e}, r, a);
      @(posedge clk); #1;
   endtask

   task automatic press_edit();
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      b_edit = 0; b_up = 0; b_dn = 0; rtc = 0; ack = 0;
      rst = 1'b1;
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; #1 rst = 1'b1; model_reset(); #1;
      total++; if (mod !== 6'd0 || field !== 3'd0)
         begin bad++; $display("FAIL reset_mod_field got mod=%b field=%0d exp 0/0", mod, field); end
      total++; if ({up_p, dn_p, act, wr_req, busy} !== 5'b0)
         begin bad++; $display("FAIL reset_ctrl got %b exp 00000", {up_p, dn_p, act, wr_req, busy}); end
      @(posedge clk); #1; rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      total++; if (busy !== 1'b0 || act !== 1'b0)
         begin bad++; $display("FAIL reset_idle got busy=%b act=%b exp 0/0", busy, act); end
   endtask

   task automatic test_act();
      do_reset();
      repeat (4) drive(0, 0, 0, 0, 0);
      total++; if (act !== 1'b0) begin bad++; $display("FAIL act_quiet got %b exp 0", act); end
      drive(0, 0, 0, 1, 0);
      total++; if (act !== 1'b1 || mod !== 6'd0)
         begin bad++; $display("FAIL act_pulse got act=%b mod=%b exp 1/000000", act, mod); end
      drive(0, 0, 0, 0, 0);
      total++; if (act !== 1'b0) begin bad++; $display("FAIL act_once got %b exp 0", act); end
   endtask

   task automatic test_edit_walk();
      do_reset();
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0);
      total++; if (act !== 1'b0) begin bad++; $display("FAIL entry_act_drop got %b exp 0", act); end
      for (int i = 0; i < 6; i++) begin
         if (i > 0) press_edit();
         total++; if (mod !== (6'd1 << i) || field !== 3'(i) || busy !== 1'b1)
            begin bad++; $display("FAIL walk i=%0d got mod=%b field=%0d busy=%b exp %b/%0d/1", i, mod, field, busy, 6'd1 << i, i); end
      end
      press_edit();
      total++; if (wr_req !== 1'b1 || busy !== 1'b1 || mod !== 6'd0 || field !== 3'd0)
         begin bad++; $display("FAIL commit_enter got wr=%b busy=%b mod=%b field=%0d exp 1/1/0/0", wr_req, busy, mod, field); end
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, 0, 1, 0);
         total++; if (wr_req !== 1'b1 || act !== 1'b0)
            begin bad++; $display("FAIL commit_hold k=%0d got wr=%b act=%b exp 1/0", k, wr_req, act); end
      end
      drive(0, 0, 0, 0, 1);
      total++; if (wr_req !== 1'b0 || busy !== 1'b0)
         begin bad++; $display("FAIL commit_ack got wr=%b busy=%b exp 0/0", wr_req, busy); end
   endtask

   task automatic test_updown();
      int nu, nd;
      do_reset();
      press_edit();
      repeat (4) press_edit();
      total++; if (field !== 3'd4 || mod !== 6'b010000)
         begin bad++; $display("FAIL ud_field got field=%0d mod=%b exp 4/010000", field, mod); end
      nu = 0; nd = 0;
      drive(0, 1, 0, 0, 0);
      repeat (3) begin drive(0, 0, 0, 0, 0); nu += int'(up_p); nd += int'(dn_p); end
      total++; if (nu != 1 || nd != 0)
         begin bad++; $display("FAIL ud_up got up=%0d dn=%0d exp 1/0", nu, nd); end
      nu = 0; nd = 0;
      drive(0, 0, 1, 0, 0);
      repeat (3) begin drive(0, 0, 0, 0, 0); nu += int'(up_p); nd += int'(dn_p); end
      total++; if (nu != 0 || nd != 1)
         begin bad++; $display("FAIL ud_down got up=%0d dn=%0d exp 0/1", nu, nd); end
      nu = 0; nd = 0;
      drive(0, 1, 1, 0, 0);
      drive(0, 1, 1, 0, 0); nu += int'(up_p); nd += int'(dn_p);
      repeat (3) begin drive(0, 0, 0, 0, 0); nu += int'(up_p); nd += int'(dn_p); end
      total++; if (nu != 0 || nd != 0)
         begin bad++; $display("FAIL ud_both got up=%0d dn=%0d exp 0/0", nu, nd); end
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0);
      total++; if (act !== 1'b0 || busy !== 1'b1 || field !== 3'd4)
         begin bad++; $display("FAIL ud_rtc got act=%b busy=%b field=%0d exp 0/1/4", act, busy, field); end
   endtask

   task automatic test_timeout();
      logic seen_wr;
      do_reset();
      press_edit();
      seen_wr = 1'b0;
      repeat (TO - 1) begin drive(0, 0, 0, 0, 0); seen_wr |= wr_req; end
      total++; if (busy !== 1'b1 || mod !== 6'd1)
         begin bad++; $display("FAIL tmo_early got busy=%b mod=%b exp 1/000001", busy, mod); end
      drive(0, 0, 0, 0, 0); seen_wr |= wr_req;
      total++; if (busy !== 1'b0 || mod !== 6'd0)
         begin bad++; $display("FAIL tmo_abort got busy=%b mod=%b exp 0/000000", busy, mod); end
      total++; if (seen_wr !== 1'b0) begin bad++; $display("FAIL tmo_no_wr got %b exp 0", seen_wr); end
   endtask

   task automatic test_repeat();
      logic [25:0] got, exp;
      logic exp_busy;
      do_reset();
      press_edit();
      got = '0; exp = '0;
      for (int i = 0; i < 26; i++) begin
         drive(0, i < 20, 0, 0, 0);
         got[i] = up_p;
      end
      exp[1] = 1'b1;
      if (AUTO) for (int j = 1 + RD; j <= 20; j += RP) exp[j] = 1'b1;
      total++; if (got !== exp) begin bad++; $display("FAIL repeat_pulses got %b exp %b", got, exp); end
      // Without repeat, the hold is not activity and the idle window expires
      exp_busy = AUTO;
      total++; if (busy !== exp_busy) begin bad++; $display("FAIL repeat_busy got %b exp %b", busy, exp_busy); end
   endtask

   task automatic test_reset_commit();
      do_reset();
      repeat (7) press_edit();
      total++; if (wr_req !== 1'b1) begin bad++; $display("FAIL rc_commit got wr=%b exp 1", wr_req); end
      #2 rst = 1'b1;
      #1;
      total++; if (wr_req !== 1'b0 || busy !== 1'b0 || mod !== 6'd0)
         begin bad++; $display("FAIL rc_async got wr=%b busy=%b mod=%b exp 0/0/0", wr_req, busy, mod); end
      model_reset();
      @(posedge clk); #1; rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      total++; if (busy !== 1'b0 || wr_req !== 1'b0)
         begin bad++; $display("FAIL rc_after got busy=%b wr=%b exp 0/0", busy, wr_req); end
   endtask

   task automatic test_random();
      int hold_left, gap_left;
      logic [2:0] btn, cur;
      logic [13:0] got_v, exp_v;
      do_reset();
      hold_left = 0; gap_left = 0; btn = 3'd0;
      for (int c = 0; c < 1500; c++) begin
         if (hold_left == 0 && gap_left == 0) begin
            case ($urandom_range(0, 4))
               0, 1: btn = 3'b001;
               2: btn = 3'b010;
               3: btn = 3'b100;
               default: btn = 3'b000;
            endcase
            hold_left = $urandom_range(1, AUTO ? 16 : 3);
            gap_left = ($urandom_range(0, 24) == 0) ? 24 : $urandom_range(1, 3);
         end
         if (hold_left > 0) begin cur = btn; hold_left--; end
         else begin cur = 3'd0; gap_left--; end
         drive(cur[0], cur[1], cur[2], $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
         got_v = {mod, field, up_p, dn_p, act, wr_req, busy};
         exp_v = {e_mod, e_field, e_up, e_dn, e_act, e_wr, e_busy};
         total++; if (got_v !== exp_v)
            begin bad++; $display("FAIL random cyc=%0d got mod/field/up/dn/act/wr/busy=%b exp %b", c, got_v, exp_v); end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_act();
      test_edit_walk();
      test_updown();
      test_timeout();
      test_repeat();
      test_reset_commit();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/field_edit_ctrl.md
FIELD_EDIT_CTRL -- requirements
Module: field_edit_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 100000000, EDIT idle cycles before abort.
REQ-002 SHALL have parameter REPEAT_DLY, default 50000000, hold cycles before the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PER, default 10000000, cycles between auto-repeat pulses.
REQ-004 SHALL have port CLK  in  1  clock; all state on rising edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports BTN_EDIT, BTN_UP, BTN_DOWN  in  1 each  debounced, CLK-synchronous button levels.
REQ-007 SHALL have port RTC_RD_VALID  in  1  one-cycle pulse: fresh RTC read data on the field registers' DATA_in.
REQ-008 SHALL have port WR_ACK  in  1  RTC write controller has accepted the edited values.
REQ-009 SHALL have port MOD  out  6  one-hot per-field Modificando: bit0 hour, 1 min, 2 sec, 3 day, 4 month, 5 year.
REQ-010 SHALL have ports UP_P, DOWN_P  out  1 each  one-cycle increment/decrement pulses to all field registers.
REQ-011 SHALL have port ACT  out  1  one-cycle Actualizar strobe to all field registers.
REQ-012 SHALL have port WR_REQ  out  1  level request to write the edited fields to the RTC.
REQ-013 SHALL have ports FIELD  out  3  current field index 0-5; BUSY  out  1  high when state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, EDIT, COMMIT; every output is registered.
REQ-015 SHALL detect rising edges of BTN_EDIT/BTN_UP/BTN_DOWN: sampled 1 at edge n after 0 at edge n-1; the response appears on outputs after edge n+1.
REQ-016 IDLE: RTC_RD_VALID SHALL produce ACT=1 for exactly one cycle, one cycle later; MOD=0, WR_REQ=0.
REQ-017 IDLE + BTN_EDIT edge SHALL go to EDIT with FIELD=0, MOD=6'b000001; any RTC_RD_VALID in that same cycle is dropped.
REQ-018 EDIT: MOD SHALL equal 1<<FIELD; ACT SHALL stay 0; RTC_RD_VALID is ignored.
REQ-019 EDIT + BTN_EDIT edge with FIELD<5 SHALL increment FIELD; with FIELD=5 SHALL go to COMMIT.
REQ-020 EDIT + BTN_UP edge (BTN_DOWN low) SHALL pulse UP_P; + BTN_DOWN edge (BTN_UP low) SHALL pulse DOWN_P; both buttons high SHALL give no pulse.
REQ-021 UP_P/DOWN_P SHALL NOT fire in the cycle a BTN_EDIT edge is taken; the BTN_EDIT edge wins.
REQ-022 EDIT timeout counter SHALL clear on any button edge and on entry; at TIMEOUT it SHALL go to IDLE with MOD=0, no WR_REQ (abort; the next read overwrites the fields).
REQ-023 COMMIT: MOD=0, WR_REQ=1 held until WR_ACK is sampled 1, then IDLE next cycle with WR_REQ=0; buttons and RTC_RD_VALID ignored.
REQ-024 The timeout counter SHALL be $clog2(TIMEOUT+1) bits, saturating, and not wrap.
REQ-025 BUSY SHALL be 1 in EDIT and COMMIT; FIELD SHALL read 0 outside EDIT.

Reset
REQ-026 RST SHALL force IDLE, FIELD=0, MOD=0, UP_P=DOWN_P=ACT=WR_REQ=BUSY=0, counters and edge registers 0 immediately, from any state.
REQ-027 RST during COMMIT SHALL drop WR_REQ without waiting for WR_ACK.

Configuration
REQ-028 With macro FIELD_EDIT_AUTOREPEAT_EN defined: in EDIT, holding BTN_UP (or BTN_DOWN) alone SHALL give the edge pulse, then a pulse after REPEAT_DLY further cycles, then one every REPEAT_PER cycles until release; holds also reset the timeout.
REQ-029 Without FIELD_EDIT_AUTOREPEAT_EN: exactly one pulse per press; no repeat counters in the netlist.

Verification (TIMEOUT=20, REPEAT_DLY=8, REPEAT_PER=3)
REQ-030 IDLE, RTC_RD_VALID pulse at cycle 5 -> ACT=1 only at cycle 6; MOD=0.
REQ-031 Six BTN_EDIT presses -> MOD steps 01,02,04,08,10,20, FIELD 0..5; 7th press -> COMMIT, WR_REQ=1; WR_ACK after 4 cycles -> IDLE, BUSY=0.
REQ-032 EDIT FIELD=4, BTN_UP press, then BTN_DOWN press, then both high -> one UP_P, one DOWN_P, no pulse for both high; RTC_RD_VALID in EDIT -> ACT stays 0.
REQ-033 EDIT with no buttons for 20 cycles -> IDLE, MOD=0, WR_REQ never asserted.
REQ-034 AUTOREPEAT_EN, BTN_UP held 20 cycles in EDIT -> UP_P at edge+1, +9, +12, +15, +18; without macro -> single UP_P.
REQ-035 RST asserted mid-COMMIT with WR_REQ=1 -> WR_REQ=0, state IDLE the same cycle, before any clock edge.
